// File: rtl/arbitro_rr_pkg.sv
// rtl/arbitro_rr_pkg.sv - shared widths and state encodings for the PCIE VC drain arbiter
package arbitro_rr_pkg;

    localparam int PCIE_DATA_WIDTH   = 10;
    localparam int PCIE_UMBRALES_L_H = 8;
    localparam int N_FIFOS           = 8;

    // Link FSM encodings, shared with the FSM that drives enable and thresholds
    typedef enum logic [1:0] {
        RESET  = 2'd0,
        INIT   = 2'd1,
        IDLE   = 2'd2,
        ACTIVE = 2'd3
    } fsm_state_t;

    typedef enum logic {
        RUN   = 1'b0,
        PAUSE = 1'b1
    } pause_state_t;

endpackage

// File: rtl/rr_priority.sv
// rtl/rr_priority.sv - combinational round-robin pick starting just after the last grant
module rr_priority
    import arbitro_rr_pkg::*;
(
    input  logic [N_FIFOS-1:0] req,
    input  logic [2:0]         last,
    output logic [N_FIFOS-1:0] grant,
    output logic [2:0]         idx,
    output logic               valid
);

    logic [2:0] cand;

    always_comb begin
        idx   = last;
        valid = 1'b0;
        cand  = last;
        // i = N_FIFOS wraps back to last itself, so a lone requester is re-granted
        for (int i = 1; i <= N_FIFOS; i++) begin
            cand = last + 3'(i);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
        grant = valid ? ({{(N_FIFOS-1){1'b0}}, 1'b1} << idx) : '0;
    end

endmodule

// File: rtl/arbitro_rr.sv
// rtl/arbitro_rr.sv - round-robin drain of eight VC FIFOs into one downstream FIFO with hysteresis
module arbitro_rr
    import arbitro_rr_pkg::*;
#(
    parameter int DATA_WIDTH   = PCIE_DATA_WIDTH,
    parameter int UMBRALES_L_H = PCIE_UMBRALES_L_H
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [UMBRALES_L_H-1:0]       umbral_L,
    input  logic [UMBRALES_L_H-1:0]       umbral_H,
    input  logic [N_FIFOS-1:0]            empty_fifo,
    input  logic [N_FIFOS*DATA_WIDTH-1:0] fifo_data,
    input  logic [UMBRALES_L_H-1:0]       out_count,
    output logic [N_FIFOS-1:0]            pop,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          push_out,
    output logic [2:0]                    grant_idx,
    output logic                          pause,
    output logic                          idle
);

    pause_state_t        state_q;
    pause_state_t        state_d;
    logic [N_FIFOS-1:0]  grant_oh;
    logic [2:0]          grant_nxt;
    logic                any_req;
    logic                issue;
    logic [2:0]          sel_d;
    logic                inflight;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // High threshold is checked first so a misconfigured L >= H parks in PAUSE
    always_comb begin
        state_d = state_q;
        if (out_count >= umbral_H) begin
            state_d = PAUSE;
        end else if ((state_q == PAUSE) && (out_count <= umbral_L)) begin
            state_d = RUN;
        end
    end

    assign pause = (state_q == PAUSE);

    rr_priority u_rr_priority (
        .req   (~empty_fifo),
        .last  (grant_idx),
        .grant (grant_oh),
        .idx   (grant_nxt),
        .valid (any_req)
    );

    // Gated by reset so no FIFO is read while the pipeline is held cleared
    assign issue = reset && enable && (state_q == RUN) && any_req;
    assign pop   = issue ? grant_oh : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_idx <= 3'd7;
            sel_d     <= 3'd0;
            inflight  <= 1'b0;
            push_out  <= 1'b0;
            data_out  <= '0;
            idle      <= 1'b0;
        end else begin
            if (issue) begin
                grant_idx <= grant_nxt;
                sel_d     <= grant_nxt;
            end
            inflight <= issue;
            push_out <= inflight;
            if (inflight) begin
                data_out <= fifo_data[sel_d*DATA_WIDTH +: DATA_WIDTH];
            end
            idle <= (&empty_fifo) && !issue && !inflight;
        end
    end

endmodule

// File: tb/tb_arbitro_rr.sv
// tb/tb_arbitro_rr.sv - scoreboard bench for arbitro_rr against a queue-based FIFO model
module tb_arbitro_rr;

    localparam int DW = 10;
    localparam int UW = 8;
    localparam int NF = 8;

    logic            clk;
    logic            reset;
    logic            enable;
    logic [UW-1:0]   umbral_L;
    logic [UW-1:0]   umbral_H;
    logic [NF-1:0]   empty_fifo;
    logic [NF*DW-1:0] fifo_data;
    logic [UW-1:0]   out_count;
    logic [NF-1:0]   pop;
    logic [DW-1:0]   data_out;
    logic            push_out;
    logic [2:0]      grant_idx;
    logic            pause;
    logic            idle;

    arbitro_rr dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .umbral_L   (umbral_L),
        .umbral_H   (umbral_H),
        .empty_fifo (empty_fifo),
        .fifo_data  (fifo_data),
        .out_count  (out_count),
        .pop        (pop),
        .data_out   (data_out),
        .push_out   (push_out),
        .grant_idx  (grant_idx),
        .pause      (pause),
        .idle       (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        int            c;
    } exp_t;

    logic [DW-1:0] fq [NF][$];
    logic [DW-1:0] rdata [NF];
    exp_t          sb [$];

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    int last_m;
    bit pause_m;
    bit pend;
    int pend_idx;
    bit pop_prev, pop_prev2, allempty_prev;
    int csr;

    for (genvar g = 0; g < NF; g++) begin : g_pack
        assign fifo_data[g*DW +: DW] = rdata[g];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        last_m        = 7;
        pause_m       = 1'b0;
        pend          = 1'b0;
        pop_prev      = 1'b0;
        pop_prev2     = 1'b0;
        allempty_prev = 1'b0;
        csr           = 0;
        sb.delete();
    endtask

    task automatic refresh_empty();
        for (int i = 0; i < NF; i++) empty_fifo[i] = (fq[i].size() == 0);
    endtask

    task automatic load(input int f, input int n);
        for (int k = 0; k < n; k++) fq[f].push_back(DW'($urandom));
    endtask

    // Rising edge plus settle: the FIFO that was popped presents its word
    task automatic advance();
        @(posedge clk);
        #1;
        if (pend) begin
            rdata[pend_idx] = fq[pend_idx].pop_front();
            pend = 1'b0;
        end
        cyc++;
    endtask

    // Model of one cycle: expected pop, then the state it leaves behind
    task automatic step();
        bit iss;
        int e_idx;
        bit all_e;
        logic [NF-1:0] exp_pop;
        iss   = 1'b0;
        e_idx = 0;
        all_e = 1'b1;
        for (int i = 0; i < NF; i++) if (fq[i].size() != 0) all_e = 1'b0;
        if (enable && !pause_m) begin
            for (int k = 1; k <= NF; k++) begin
                int j;
                j = (last_m + k) % NF;
                if (!iss && fq[j].size() != 0) begin
                    iss   = 1'b1;
                    e_idx = j;
                end
            end
        end
        exp_pop = iss ? (NF'(1) << e_idx) : '0;
        chk("pop", 32'(pop), 32'(exp_pop));
        chk("pause", 32'(pause), 32'(pause_m));
        chk("grant_idx", 32'(grant_idx), 32'(last_m));
        chk("idle", 32'(idle), 32'((csr > 0) && allempty_prev && !pop_prev && !pop_prev2));
        if (iss) begin
            sb.push_back('{d: fq[e_idx][0], c: cyc + 2});
            last_m   = e_idx;
            pend     = 1'b1;
            pend_idx = e_idx;
        end
        if (out_count >= umbral_H) pause_m = 1'b1;
        else if (pause_m && out_count <= umbral_L) pause_m = 1'b0;
        pop_prev2     = pop_prev;
        pop_prev      = iss;
        allempty_prev = all_e;
        csr++;
    endtask

    task automatic check_now();
        refresh_empty();
        @(negedge clk);
        step();
    endtask

    task automatic run(input int n);
        repeat (n) begin
            advance();
            check_now();
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (push_out) begin
                if (sb.size() == 0) begin
                    chk("push_unexpected", 32'(push_out), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("data_out", 32'(data_out), 32'(e.d));
                    chk("push_cycle", 32'(cyc), 32'(e.c));
                end
            end else if (sb.size() > 0 && sb[0].c <= cyc) begin
                chk("push_missing", 32'(push_out), 32'd1);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        for (int i = 0; i < NF; i++) rdata[i] = '0;
        reset      = 1'b0;
        enable     = 1'b1;
        umbral_L   = 8'd2;
        umbral_H   = 8'd8;
        out_count  = 8'd0;
        empty_fifo = '1;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pop", 32'(pop), 32'd0);
        chk("rst_push", 32'(push_out), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_grant", 32'(grant_idx), 32'd7);
        chk("rst_pause", 32'(pause), 32'd0);
        chk("rst_idle", 32'(idle), 32'd0);

        // All empty after reset release
        advance();
        reset = 1'b1;
        check_now();
        run(4);

        // FIFOs 0, 3, 5 with two words each
        advance();
        load(0, 2); load(3, 2); load(5, 2);
        check_now();
        run(9);
        chk("grant_end_5", 32'(grant_idx), 32'd5);

        // Single FIFO drains back to back
        advance();
        load(6, 4);
        check_now();
        run(8);

        // Hysteresis: ramp into pause, then fall back below L
        advance();
        umbral_L = 8'd2; umbral_H = 8'd6; out_count = 8'd5;
        load(1, 10); load(2, 10);
        check_now();
        run(2);
        advance(); out_count = 8'd6; check_now();
        run(4);
        advance(); out_count = 8'd3; check_now();
        run(2);
        advance(); out_count = 8'd2; check_now();
        run(3);

        // Misconfigured thresholds hold pause
        advance();
        umbral_L = 8'd7; umbral_H = 8'd4; out_count = 8'd5;
        check_now();
        run(4);
        chk("misconf_pause", 32'(pause), 32'd1);

        // Reset one cycle after a pop drops that word
        advance();
        umbral_L = 8'd2; umbral_H = 8'd8; out_count = 8'd0;
        check_now();
        run(4);
        advance();
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rst_mid_pop", 32'(pop), 32'd0);
        chk("rst_mid_grant", 32'(grant_idx), 32'd7);
        chk("rst_mid_push", 32'(push_out), 32'd0);
        advance();
        reset = 1'b1;
        load(0, 1); load(4, 1);
        check_now();
        chk("post_rst_first", 32'(pop), 32'd1);
        run(6);

        // Randomized traffic, enable and thresholds
        for (int n = 0; n < 400; n++) begin
            advance();
            if ($urandom_range(0, 2) == 0) begin
                int f;
                f = $urandom_range(0, NF - 1);
                if (fq[f].size() < 6) load(f, $urandom_range(1, 3));
            end
            enable = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) == 0) out_count = UW'($urandom_range(0, 9));
            if ($urandom_range(0, 31) == 0) begin
                umbral_H = UW'($urandom_range(1, 9));
                umbral_L = UW'($urandom_range(0, 9));
            end
            check_now();
        end

        // Drain in-flight words and confirm nothing is owed
        advance();
        enable = 1'b0;
        check_now();
        run(5);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
